cmd_interp_n: RTL and testbench
===============================

Name: cmd_interp_n

Overview:
- Parametrised successor to the 2-digit command interpreter.
- Consumes ASCII bytes from the UART receive path, one per `start` strobe. Assembles operands A and B of DIGITS digits each, plus an operator code, then issues a one-cycle `rdy` to the ALU/div stage.
- New relative to the previous generation:
  - configurable digit count and radix (decimal or hex);
  - operator replacement;
  - digit-overflow and error reporting.

Parameters:
DIGITS, 2, max digits per operand (1..8); operand width OW = 4*DIGITS
HEX, 0, 1 = accept 'A'-'F'/'a'-'f' as digit values 10-15; 0 = decimal only

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
start  input  1  one-cycle strobe: `data` valid this cycle
data  input  8  ASCII character
op_A  output  OW  operand A, nibble per digit, MS digit first entered
op_B  output  OW  operand B, same format
cmd  output  4  operator code
rdy  output  1  one-cycle pulse: op_A/op_B/cmd valid for computation
err  output  1  one-cycle pulse: character rejected
ovf  output  1  sticky: digit dropped because operand already had DIGITS digits

Behaviour:
- Reset (rst=0 at an edge): op_A=op_B=0, cmd=0, rdy=0, err=0, ovf=0, state=S_A0, digit counters=0.
- Character classes:
  - digit: 0x30-0x39 gives 0-9; with HEX=1, 0x41-0x46/0x61-0x66 gives 10-15.
  - operators: '+'(0x2B)=1, '-'(0x2D)=2, '*'(0x2A)=3, '/'(0x2F)=4, '%'(0x25)=5.
  - equals: '='(0x3D) or CR(0x0D).
  - ESC: 0x1B.
  - anything else: unknown.
- Pipeline:
  - edge k samples start=1 and registers the decoded class and value;
  - edge k+1 performs the action (regs/state updated);
  - `rdy`/`err` are high for the single cycle after edge k+2.
  - `start` may be high on consecutive cycles; each byte is processed in order.
- Digit entry: operand <= {operand[OW-5:0], value}, count++. If count==DIGITS, the operand is unchanged, ovf<=1, err pulses.
- States:
  - S_A0 (no A digits):
    - digit -> load A, go S_A;
    - operator or equals -> err, stay.
  - S_A (A has >=1 digit):
    - digit -> shift into A;
    - operator -> cmd<=code, go S_B0;
    - equals -> err.
  - S_B0 (operator held, no B digits):
    - digit -> load B, go S_B;
    - operator -> cmd replaced by new code, no err;
    - equals -> err.
  - S_B:
    - digit -> shift into B;
    - equals -> go S_DONE, rdy pulse;
    - operator -> err, cmd unchanged.
  - S_DONE:
    - op_A/op_B/cmd held;
    - digit -> A<=value, B<=0, cmd<=0, ovf<=0, counts A=1/B=0, go S_A;
    - operator -> err;
    - equals -> err, no second rdy.
- ESC in any state: op_A, op_B, cmd, ovf and counts cleared, go S_A0, no err.
- Unknown character in any state: err pulse, no other change.
- ovf clears only on ESC, reset, or a digit leaving S_DONE.
- Reset mid-pipeline: in-flight bytes are discarded; no rdy/err pulse after reset.
- rdy and err are never high in the same cycle.

Optional Feature:
- Macro `CMD_INTERP_BACKSPACE_EN`.
- Defined: BS (0x08) is an edit character, with no err in any of these cases:
  - in S_A/S_B: operand <= operand >> 4, count--; if count becomes 0, go S_A0/S_B0 respectively;
  - in S_B0: cmd<=0, go S_A;
  - in S_A0 or S_DONE: ignored.
- Not defined: 0x08 is an unknown character (err pulse).

Test Plan:
- Reset, then send "12+34=" with DIGITS=2: one rdy pulse, op_A=0x12, op_B=0x34, cmd=1, no err; rdy 2 cycles after the '=' start cycle.
- DIGITS=4, HEX=1: send "aF3-7" then CR: op_A=0x0AF3, op_B=0x0007, cmd=2, rdy pulse.
- DIGITS=2: send "123*4=": third digit gives err+ovf; op_A=0x12, cmd=3, op_B=0x04, rdy pulse, ovf stays 1.
- Send "5+*9=": cmd ends 3 with no err; then send "7": op_A=0x07, op_B=0, cmd=0, ovf=0, state S_A.
- Send "56" ESC "=" then "x": op regs 0 after ESC; two err pulses, no rdy; then rst=0 mid-stream: all outputs 0 next cycle.
- `CMD_INTERP_BACKSPACE_EN`: "12" BS "+" BS "3-4=" gives op_A=0x13, cmd=2, op_B=0x04, rdy, no err; without macro the first BS gives an err pulse.

Source files
------------

// File: rtl/cmd_interp_n_if.sv
// ---------------------------------------------------------------------------
// cmd_interp_n_if
// Byte-in / operands-out bundle of the command interpreter.
//   start, data      : one ASCII byte per start strobe (driven by master)
//   op_A, op_B       : operands, one nibble per digit, OW = 4*DIGITS bits
//   cmd              : operator code (1..5, 0 = none)
//   rdy, err         : one-cycle pulses (result ready / byte rejected)
//   ovf              : sticky digit-overflow flag
// Modports: master (byte source, result sink), slave (interpreter).
// ---------------------------------------------------------------------------
interface cmd_interp_n_if #(
  parameter int DIGITS = 2
) ();
  localparam int OW = 4 * DIGITS;

  logic          start;
  logic [7:0]    data;
  logic [OW-1:0] op_A;
  logic [OW-1:0] op_B;
  logic [3:0]    cmd;
  logic          rdy;
  logic          err;
  logic          ovf;

  modport master (
    output start, data,
    input  op_A, op_B, cmd, rdy, err, ovf
  );

  modport slave (
    input  start, data,
    output op_A, op_B, cmd, rdy, err, ovf
  );
endinterface

// File: rtl/cmd_interp_n.sv
// ---------------------------------------------------------------------------
// cmd_interp_n
// ASCII command interpreter: assembles "A <op> B =" from a byte stream and
// hands operands plus operator code to the arithmetic stage.
//
// Parameters:
//   DIGITS : max digits per operand (1..8), operand width OW = 4*DIGITS
//   HEX    : 1 = 'A'-'F' / 'a'-'f' are digit values 10..15
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-low reset
//   bus    : cmd_interp_n_if.slave (start/data in; op_A/op_B/cmd/rdy/err/ovf out)
// Optional feature:
//   CMD_INTERP_BACKSPACE_EN : when defined, BS (0x08) edits the current
//   entry; otherwise BS is an unknown character and pulses err.
//
// Pipeline: the byte sampled at edge k is classified into in_* registers,
// acted on at edge k+1, and the result appears on the outputs after k+2.
// All outputs come from one output register stage so that op_A/op_B/cmd
// are a coherent snapshot in the cycle rdy is high, even when another byte
// follows the '=' back to back.
// ---------------------------------------------------------------------------
module cmd_interp_n #(
  parameter int DIGITS = 2,
  parameter int HEX    = 0
) (
  input  logic          clk,
  input  logic          rst,
  cmd_interp_n_if.slave bus
);
  localparam int         OW    = 4 * DIGITS;
  localparam logic [3:0] DIG_L = 4'(DIGITS);

  // Entry states
  localparam logic [2:0] S_A0   = 3'd0;  // no A digits yet
  localparam logic [2:0] S_A    = 3'd1;  // A has at least one digit
  localparam logic [2:0] S_B0   = 3'd2;  // operator held, no B digits
  localparam logic [2:0] S_B    = 3'd3;  // B has at least one digit
  localparam logic [2:0] S_DONE = 3'd4;  // expression complete, held

  // Character classes
  localparam logic [2:0] CL_DIGIT = 3'd0;
  localparam logic [2:0] CL_OP    = 3'd1;
  localparam logic [2:0] CL_EQ    = 3'd2;
  localparam logic [2:0] CL_ESC   = 3'd3;
  localparam logic [2:0] CL_UNK   = 3'd4;
`ifdef CMD_INTERP_BACKSPACE_EN
  localparam logic [2:0] CL_BS    = 3'd5;
`endif

  // Append one digit at the least-significant end of an operand.
  function automatic logic [OW-1:0] shift_in(input logic [OW-1:0] cur,
                                             input logic [3:0]    v);
    shift_in = (cur << 4'd4) | OW'(v);
  endfunction

  // Decode outputs
  logic [2:0]    dec_cls_s;
  logic [3:0]    dec_val_s;

  // Stage 1: classified input byte
  logic          in_vld_r;
  logic [2:0]    in_cls_r;
  logic [3:0]    in_val_r;

  // Stage 2: architectural state
  logic [2:0]    state_r,  state_s;
  logic [OW-1:0] a_r,      a_s;
  logic [OW-1:0] b_r,      b_s;
  logic [3:0]    cmd_r,    cmd_s;
  logic [3:0]    cnt_a_r,  cnt_a_s;
  logic [3:0]    cnt_b_r,  cnt_b_s;
  logic          ovf_r,    ovf_s;
  logic          act_rdy_r, rdy_s;
  logic          act_err_r, err_s;

  // Stage 3: output snapshot
  logic [OW-1:0] out_a_r;
  logic [OW-1:0] out_b_r;
  logic [3:0]    out_cmd_r;
  logic          out_rdy_r;
  logic          out_err_r;
  logic          out_ovf_r;

  // Classify the incoming byte and extract its digit value / operator code.
  always_comb begin
    dec_cls_s = CL_UNK;
    dec_val_s = 4'h0;
    if ((bus.data >= 8'h30) && (bus.data <= 8'h39)) begin
      dec_cls_s = CL_DIGIT;
      dec_val_s = bus.data[3:0];
    end else if ((HEX != 0) &&
                 (((bus.data >= 8'h41) && (bus.data <= 8'h46)) ||
                  ((bus.data >= 8'h61) && (bus.data <= 8'h66)))) begin
      // 'A'/'a' have low nibble 1, so +9 maps A..F onto 10..15
      dec_cls_s = CL_DIGIT;
      dec_val_s = bus.data[3:0] + 4'd9;
    end else begin
      case (bus.data)
        8'h2B: begin dec_cls_s = CL_OP; dec_val_s = 4'd1; end
        8'h2D: begin dec_cls_s = CL_OP; dec_val_s = 4'd2; end
        8'h2A: begin dec_cls_s = CL_OP; dec_val_s = 4'd3; end
        8'h2F: begin dec_cls_s = CL_OP; dec_val_s = 4'd4; end
        8'h25: begin dec_cls_s = CL_OP; dec_val_s = 4'd5; end
        8'h3D, 8'h0D: dec_cls_s = CL_EQ;
        8'h1B: dec_cls_s = CL_ESC;
`ifdef CMD_INTERP_BACKSPACE_EN
        8'h08: dec_cls_s = CL_BS;
`endif
        default: dec_cls_s = CL_UNK;
      endcase
    end
  end

  // Stage 1: register the classified byte and its valid flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_vld_r <= 1'b0;
      in_cls_r <= CL_UNK;
      in_val_r <= 4'h0;
    end else begin
      in_vld_r <= bus.start;
      in_cls_r <= dec_cls_s;
      in_val_r <= dec_val_s;
    end
  end

  // Stage 2 next-state: act on the classified byte according to the state.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    cmd_s   = cmd_r;
    cnt_a_s = cnt_a_r;
    cnt_b_s = cnt_b_r;
    ovf_s   = ovf_r;
    rdy_s   = 1'b0;
    err_s   = 1'b0;
    if (in_vld_r) begin
      case (in_cls_r)
        CL_DIGIT: begin
          case (state_r)
            S_A0: begin
              a_s     = OW'(in_val_r);
              cnt_a_s = 4'd1;
              state_s = S_A;
            end
            S_A: begin
              if (cnt_a_r == DIG_L) begin
                ovf_s = 1'b1;
                err_s = 1'b1;
              end else begin
                a_s     = shift_in(a_r, in_val_r);
                cnt_a_s = cnt_a_r + 4'd1;
              end
            end
            S_B0: begin
              b_s     = OW'(in_val_r);
              cnt_b_s = 4'd1;
              state_s = S_B;
            end
            S_B: begin
              if (cnt_b_r == DIG_L) begin
                ovf_s = 1'b1;
                err_s = 1'b1;
              end else begin
                b_s     = shift_in(b_r, in_val_r);
                cnt_b_s = cnt_b_r + 4'd1;
              end
            end
            S_DONE: begin
              // first digit of a new expression
              a_s     = OW'(in_val_r);
              b_s     = '0;
              cmd_s   = 4'd0;
              ovf_s   = 1'b0;
              cnt_a_s = 4'd1;
              cnt_b_s = 4'd0;
              state_s = S_A;
            end
            default: state_s = S_A0;
          endcase
        end
        CL_OP: begin
          case (state_r)
            S_A: begin
              cmd_s   = in_val_r;
              state_s = S_B0;
            end
            S_B0:    cmd_s = in_val_r;  // operator replacement
            default: err_s = 1'b1;
          endcase
        end
        CL_EQ: begin
          if (state_r == S_B) begin
            state_s = S_DONE;
            rdy_s   = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
        CL_ESC: begin
          a_s     = '0;
          b_s     = '0;
          cmd_s   = 4'd0;
          ovf_s   = 1'b0;
          cnt_a_s = 4'd0;
          cnt_b_s = 4'd0;
          state_s = S_A0;
        end
`ifdef CMD_INTERP_BACKSPACE_EN
        CL_BS: begin
          case (state_r)
            S_A: begin
              a_s     = a_r >> 4'd4;
              cnt_a_s = cnt_a_r - 4'd1;
              state_s = (cnt_a_r == 4'd1) ? S_A0 : S_A;
            end
            S_B: begin
              b_s     = b_r >> 4'd4;
              cnt_b_s = cnt_b_r - 4'd1;
              state_s = (cnt_b_r == 4'd1) ? S_B0 : S_B;
            end
            S_B0: begin
              // withdraw the operator, back to editing A
              cmd_s   = 4'd0;
              state_s = S_A;
            end
            default: state_s = state_r;  // S_A0 / S_DONE: ignored
          endcase
        end
`endif
        default: err_s = 1'b1;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Stage 2: commit the architectural state and the pulse requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= S_A0;
      a_r       <= '0;
      b_r       <= '0;
      cmd_r     <= 4'd0;
      cnt_a_r   <= 4'd0;
      cnt_b_r   <= 4'd0;
      ovf_r     <= 1'b0;
      act_rdy_r <= 1'b0;
      act_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      cmd_r     <= cmd_s;
      cnt_a_r   <= cnt_a_s;
      cnt_b_r   <= cnt_b_s;
      ovf_r     <= ovf_s;
      act_rdy_r <= rdy_s;
      act_err_r <= err_s;
    end
  end

  // Stage 3: output snapshot register, aligned with the rdy/err pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_a_r   <= '0;
      out_b_r   <= '0;
      out_cmd_r <= 4'd0;
      out_rdy_r <= 1'b0;
      out_err_r <= 1'b0;
      out_ovf_r <= 1'b0;
    end else begin
      out_a_r   <= a_r;
      out_b_r   <= b_r;
      out_cmd_r <= cmd_r;
      out_rdy_r <= act_rdy_r;
      out_err_r <= act_err_r;
      out_ovf_r <= ovf_r;
    end
  end

  assign bus.op_A = out_a_r;
  assign bus.op_B = out_b_r;
  assign bus.cmd  = out_cmd_r;
  assign bus.rdy  = out_rdy_r;
  assign bus.err  = out_err_r;
  assign bus.ovf  = out_ovf_r;
endmodule

// File: tb/tb_cmd_interp_n.sv
// ---------------------------------------------------------------------------
// tb_cmd_interp_n
// Two interpreters share one byte stream: inst 0 (DIGITS=2, decimal) and
// inst 1 (DIGITS=4, HEX). A digit-list model of each expression predicts
// every output every cycle; a table of scripted expressions checks final
// results and pulse counts; short hand sequences cover rdy latency and a
// mid-stream reset.
// ---------------------------------------------------------------------------
module tb_cmd_interp_n;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cmd_interp_n_if #(.DIGITS(2)) bus0 ();
  cmd_interp_n_if #(.DIGITS(4)) bus1 ();

  cmd_interp_n #(.DIGITS(2), .HEX(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  cmd_interp_n #(.DIGITS(4), .HEX(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;

  // ---- reference model: operands kept as lists of digit values ----
  int dg [2] = '{2, 4};
  int hx [2] = '{0, 1};
  int da [2][8];
  int db [2][8];
  int na [2];
  int nb [2];
  int mop [2];
  bit have_op [2];
  bit done [2];
  bit movf [2];
  bit erdy [2];
  bit eerr [2];
  int nrdy [2];
  int nerr [2];
  bit p1v, p2v;
  logic [7:0] p1d, p2d;

  function automatic int digval(int i, logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (hx[i] != 0 && c >= "A" && c <= "F") return int'(c) - 55;
    if (hx[i] != 0 && c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic int opcode(logic [7:0] c);
    case (c)
      "+": return 1;
      "-": return 2;
      "*": return 3;
      "/": return 4;
      "%": return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mval(int i, bit second);
    logic [31:0] v = 32'd0;
    int n = second ? nb[i] : na[i];
    for (int j = 0; j < n; j++)
      v = v * 32'd16 + 32'(second ? db[i][j] : da[i][j]);
    return v;
  endfunction

  task automatic m_clear(int i);
    na[i] = 0; nb[i] = 0; mop[i] = 0;
    have_op[i] = 1'b0; done[i] = 1'b0; movf[i] = 1'b0;
  endtask

  task automatic m_step(int i, logic [7:0] c);
    int v = digval(i, c);
    int k = opcode(c);
    if (v >= 0) begin
      if (done[i]) begin
        m_clear(i);
        da[i][0] = v; na[i] = 1;
      end else if (!have_op[i]) begin
        if (na[i] == dg[i]) begin movf[i] = 1'b1; eerr[i] = 1'b1; end
        else begin da[i][na[i]] = v; na[i]++; end
      end else begin
        if (nb[i] == dg[i]) begin movf[i] = 1'b1; eerr[i] = 1'b1; end
        else begin db[i][nb[i]] = v; nb[i]++; end
      end
    end else if (k != 0) begin
      if (done[i] || na[i] == 0 || (have_op[i] && nb[i] > 0)) eerr[i] = 1'b1;
      else begin have_op[i] = 1'b1; mop[i] = k; end
    end else if (c == "=" || c == 8'h0D) begin
      if (!done[i] && have_op[i] && nb[i] > 0) begin done[i] = 1'b1; erdy[i] = 1'b1; end
      else eerr[i] = 1'b1;
    end else if (c == 8'h1B) begin
      m_clear(i);
`ifdef CMD_INTERP_BACKSPACE_EN
    end else if (c == 8'h08) begin
      if (done[i]) begin
        na[i] = na[i];
      end else if (!have_op[i]) begin
        if (na[i] > 0) na[i]--;
      end else if (nb[i] > 0) begin
        nb[i]--;
      end else begin
        have_op[i] = 1'b0; mop[i] = 0;
      end
`endif
    end else begin
      eerr[i] = 1'b1;
    end
  endtask

  function automatic logic [70:0] act_vec(int i);
    if (i == 0)
      return {24'd0, bus0.op_A, 24'd0, bus0.op_B, bus0.cmd, bus0.rdy, bus0.err, bus0.ovf};
    return {16'd0, bus1.op_A, 16'd0, bus1.op_B, bus1.cmd, bus1.rdy, bus1.err, bus1.ovf};
  endfunction

  function automatic logic [70:0] exp_vec(int i);
    return {mval(i, 1'b0), mval(i, 1'b1), 4'(mop[i]), erdy[i], eerr[i], movf[i]};
  endfunction

  // One clock: drive inputs, advance the model past the edge, check at negedge.
  task automatic cycle(logic s, logic [7:0] d);
    logic [70:0] a, e;
    bus0.start = s; bus0.data = d;
    bus1.start = s; bus1.data = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin erdy[i] = 1'b0; eerr[i] = 1'b0; end
    if (!rst) begin
      m_clear(0); m_clear(1);
      p1v = 1'b0; p2v = 1'b0;
    end else begin
      if (p2v) begin m_step(0, p2d); m_step(1, p2d); end
      p2v = p1v; p2d = p1d;
      p1v = s;   p1d = d;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      a = act_vec(i);
      e = exp_vec(i);
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_cycle inst%0d t=%0t: got A=%h B=%h cmd=%h rdy/err/ovf=%b, want A=%h B=%h cmd=%h rdy/err/ovf=%b",
                 i, $time, a[70:39], a[38:7], a[6:3], a[2:0], e[70:39], e[38:7], e[6:3], e[2:0]);
      end
    end
    nrdy[0] += int'(bus0.rdy); nerr[0] += int'(bus0.err);
    nrdy[1] += int'(bus1.rdy); nerr[1] += int'(bus1.err);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle(1'b0, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin nrdy[i] = 0; nerr[i] = 0; end
  endtask

  task automatic send_str(string s);
    for (int j = 0; j < s.len(); j++) cycle(1'b1, s[j]);
    for (int j = 0; j < 4; j++) cycle(1'b0, 8'h00);
  endtask

  task automatic expect_val(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---- scripted expression table ----
  typedef struct {
    string       s;
    int          inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cmd;
    logic        ovf;
    int          n_rdy;
    int          n_err;
  } vec_t;

  vec_t tbl [$];

  task automatic add_row(string s, int inst, logic [31:0] a, logic [31:0] b,
                         logic [3:0] cmd, logic ovf, int n_rdy, int n_err);
    vec_t r;
    r.s = s; r.inst = inst; r.a = a; r.b = b; r.cmd = cmd;
    r.ovf = ovf; r.n_rdy = n_rdy; r.n_err = n_err;
    tbl.push_back(r);
  endtask

  initial begin
    logic [70:0] a;
    string alpha;
    bus0.start = 1'b0; bus0.data = 8'h00;
    bus1.start = 1'b0; bus1.data = 8'h00;
    @(negedge clk);

    add_row("12+34=",       0, 32'h12,   32'h34,   4'd1, 1'b0, 1, 0);
    add_row("12+34=",       1, 32'h0012, 32'h0034, 4'd1, 1'b0, 1, 0);
    add_row("aF3-7\015",    1, 32'h0AF3, 32'h0007, 4'd2, 1'b0, 1, 0);
    add_row("123*4=",       0, 32'h12,   32'h04,   4'd3, 1'b1, 1, 1);
    add_row("123*4=",       1, 32'h0123, 32'h0004, 4'd3, 1'b0, 1, 0);
    add_row("5+*9=7",       0, 32'h07,   32'h00,   4'd0, 1'b0, 1, 0);
    add_row("56\033=x",     0, 32'h00,   32'h00,   4'd0, 1'b0, 0, 2);
`ifdef CMD_INTERP_BACKSPACE_EN
    add_row("12\010+\0103-4=", 0, 32'h13, 32'h04,  4'd2, 1'b0, 1, 0);
`else
    add_row("12\010+\0103-4=", 0, 32'h12, 32'h34,  4'd1, 1'b0, 1, 3);
`endif

    // reset state
    do_reset();
    expect_val("reset_outputs_inst0", 32'(act_vec(0)), 32'd0);
    expect_val("reset_outputs_inst1", 32'(act_vec(1)), 32'd0);

    // table-driven expressions
    foreach (tbl[r]) begin
      do_reset();
      send_str(tbl[r].s);
      a = act_vec(tbl[r].inst);
      tests++;
      if (a[70:39] !== tbl[r].a || a[38:7] !== tbl[r].b || a[6:3] !== tbl[r].cmd ||
          a[0] !== tbl[r].ovf || nrdy[tbl[r].inst] != tbl[r].n_rdy ||
          nerr[tbl[r].inst] != tbl[r].n_err) begin
        fails++;
        $display("FAIL table_row%0d inst%0d: got A=%h B=%h cmd=%h ovf=%b rdys=%0d errs=%0d, want A=%h B=%h cmd=%h ovf=%b rdys=%0d errs=%0d",
                 r, tbl[r].inst, a[70:39], a[38:7], a[6:3], a[0], nrdy[tbl[r].inst], nerr[tbl[r].inst],
                 tbl[r].a, tbl[r].b, tbl[r].cmd, tbl[r].ovf, tbl[r].n_rdy, tbl[r].n_err);
      end
    end

    // rdy latency: high only in the cycle after the second edge following '='
    do_reset();
    cycle(1'b1, "1"); cycle(1'b1, "2"); cycle(1'b1, "+"); cycle(1'b1, "3");
    cycle(1'b1, "=");
    expect_val("rdy_after_edge_k",   32'(bus0.rdy), 32'd0);
    cycle(1'b0, 8'h00);
    expect_val("rdy_after_edge_k1",  32'(bus0.rdy), 32'd0);
    cycle(1'b0, 8'h00);
    expect_val("rdy_after_edge_k2",  32'(bus0.rdy), 32'd1);
    expect_val("opA_with_rdy",       32'(bus0.op_A), 32'h12);
    cycle(1'b0, 8'h00);
    expect_val("rdy_single_cycle",   32'(bus0.rdy), 32'd0);

    // reset with bytes in flight: everything zero, no late pulses
    do_reset();
    cycle(1'b1, "5"); cycle(1'b1, "6"); cycle(1'b1, "x");
    rst = 1'b0;
    cycle(1'b1, "=");
    rst = 1'b1;
    expect_val("midreset_inst0", 32'(act_vec(0)), 32'd0);
    cycle(1'b0, 8'h00); cycle(1'b0, 8'h00); cycle(1'b0, 8'h00);
    expect_val("midreset_no_pulse", 32'(nerr[0] + nrdy[0] + nerr[1] + nrdy[1]), 32'd0);

    // randomized stream against the model
    alpha = "0123456789aAfFcB+-*/%==\015\033\010xG 4419";
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) != 0)
        cycle(1'b1, alpha[$urandom_range(0, alpha.len() - 1)]);
      else
        cycle(1'b0, 8'($urandom_range(0, 255)));
    end
    rst = 1'b1;
    for (int n = 0; n < 4; n++) cycle(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
